// File: rtl/w_ctrl_gray.sv
// rtl/w_ctrl_gray.sv - write-side pointer/flag controller for the dual-clock FIFO
// Binary write pointer with Gray copy, read-pointer synchroniser, full/almost-full/level/overflow.
module w_ctrl_gray #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 12
) (
    input  logic              w_clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [ADDR_W:0]   r_gptr,
    input  logic              ovf_clr,
    output logic              w_ram_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   w_gptr,
    output logic              w_full,
    output logic              w_almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              w_overflow
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);

    logic [ADDR_W:0] bin_q, bin_d;
    logic [ADDR_W:0] gray_q, gray_d;
    logic [ADDR_W:0] level_q, lvl_d;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rg_sync, rb_sync, full_cmp;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign accept  = w_en & ~full_q;
    assign rg_sync = sync_q[SYNC_STAGES-1];

    // The top two Gray bits differ exactly when the write pointer is one lap ahead.
    assign full_cmp = {~rg_sync[ADDR_W:ADDR_W-1], rg_sync[ADDR_W-2:0]};

    always_comb begin
        rb_sync = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rb_sync[i] = ^(rg_sync >> i);
        end
    end

    always_comb begin
        bin_d  = bin_q + {{ADDR_W{1'b0}}, accept};
        gray_d = bin_d ^ (bin_d >> 1);
        lvl_d  = bin_d - rb_sync;
        full_d = (gray_d == full_cmp);
        af_d   = (lvl_d >= AF_LVL);
        ovf_d  = ovf_q;
        if (w_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= lvl_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            sync_q[0] <= r_gptr;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign w_ram_we      = accept;
    assign w_addr        = bin_q[ADDR_W-1:0];
    assign w_gptr        = gray_q;
    assign w_full        = full_q;
    assign w_almost_full = af_q;
    assign w_level       = level_q;
    assign w_overflow    = ovf_q;

endmodule

// File: tb/tb_w_ctrl_gray.sv
// tb/tb_w_ctrl_gray.sv - randomized/directed bench for w_ctrl_gray against a count-based model
module tb_w_ctrl_gray;

    localparam int A = 4, S = 2, AF = 12, D = 16;

    logic         w_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         w_en = 1'b0, ovf_clr = 1'b0;
    logic [A:0]   r_gptr = '0;
    logic         w_ram_we, w_full, w_almost_full, w_overflow;
    logic [A-1:0] w_addr;
    logic [A:0]   w_gptr, w_level;

    logic       b_en = 1'b0, b_clr = 1'b0;
    logic [2:0] b_rg = '0;
    logic       b_we, b_full, b_af, b_ovf;
    logic [1:0] b_addr;
    logic [2:0] b_gptr, b_lvl;

    always #5 w_clk = ~w_clk;

    w_ctrl_gray #(.ADDR_W(A), .SYNC_STAGES(S), .AF_THRESH(AF)) dut (
        .w_clk(w_clk), .rst_n(rst_n), .w_en(w_en), .r_gptr(r_gptr), .ovf_clr(ovf_clr),
        .w_ram_we(w_ram_we), .w_addr(w_addr), .w_gptr(w_gptr), .w_full(w_full),
        .w_almost_full(w_almost_full), .w_level(w_level), .w_overflow(w_overflow)
    );

    w_ctrl_gray #(.ADDR_W(2), .SYNC_STAGES(3), .AF_THRESH(4)) dut_b (
        .w_clk(w_clk), .rst_n(rst_n), .w_en(b_en), .r_gptr(b_rg), .ovf_clr(b_clr),
        .w_ram_we(b_we), .w_addr(b_addr), .w_gptr(b_gptr), .w_full(b_full),
        .w_almost_full(b_af), .w_level(b_lvl), .w_overflow(b_ovf)
    );

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: total writes accepted and total reads as plain integers.
    int   wcnt, rd, m_lvl;
    int   rhist[$];
    bit   m_full, m_af, m_ovf;
    logic [A:0] prev_g;

    function automatic logic [A:0] gray(input int v);
        logic [A:0] b;
        b = v[A:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wcnt = 0; rd = 0; m_lvl = 0;
        m_full = 0; m_af = 0; m_ovf = 0; prev_g = '0;
        rhist.delete();
        repeat (S) rhist.push_back(0);
    endtask

    task automatic cycle();
        int seen;
        #1;
        chk("ram_we", w_ram_we, w_en & ~m_full);
        chk("addr", w_addr, wcnt % D);
        @(posedge w_clk);
        if (w_en && m_full) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (w_en && !m_full) wcnt++;
        seen = rhist.pop_front();
        rhist.push_back(rd);
        m_lvl  = wcnt - seen;
        m_full = (m_lvl == D);
        m_af   = (m_lvl >= AF);
        #1;
        chk("gptr", w_gptr, gray(wcnt));
        chk("gray_step", $countones(w_gptr ^ prev_g) <= 1, 1);
        prev_g = w_gptr;
        chk("full", w_full, m_full);
        chk("afull", w_almost_full, m_af);
        chk("level", w_level, m_lvl);
        chk("ovf", w_overflow, m_ovf);
        @(negedge w_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, guard;
        model_reset();
        w_en = 1'b1;
        #12;
        chk("rst_ram_we", w_ram_we, 1);
        chk("rst_gptr", w_gptr, 0);
        chk("rst_level", w_level, 0);
        chk("rst_full", {w_full, w_almost_full, w_overflow}, 0);
        chk("rst_b", {b_full, b_af, b_lvl, b_gptr}, 0);
        w_en = 1'b0;
        @(negedge w_clk);
        rst_n = 1'b1;

        // Small configuration: depth 4, three sync stages
        b_en = 1'b1;
        repeat (3) cycle();
        chk("b_full_3", b_full, 0);
        chk("b_af_3", b_af, 0);
        cycle();
        chk("b_full_4", b_full, 1);
        chk("b_af_4", b_af, 1);
        chk("b_lvl_4", b_lvl, 4);
        b_en = 1'b0;
        b_rg = 3'b001;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("b_full_hold", b_full, 1);
        end
        cycle();
        chk("b_full_rel", b_full, 0);
        chk("b_lvl_rel", b_lvl, 3);

        // Fill the 16-deep FIFO
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (i == 10) chk("af_11", w_almost_full, 0);
            if (i == 11) chk("af_12", w_almost_full, 1);
            if (i == 14) chk("full_15", w_full, 0);
        end
        chk("full_16", w_full, 1);
        chk("level_16", w_level, 16);
        chk("gptr_16", w_gptr, 5'b11000);

        // Overflow handling
        repeat (3) cycle();
        chk("ovf_set", w_overflow, 1);
        chk("addr_hold", w_addr, 0);
        w_en = 1'b0;
        cycle();
        chk("ovf_hold", w_overflow, 1);
        w_en = 1'b1; ovf_clr = 1'b1;
        cycle();
        chk("ovf_setwins", w_overflow, 1);
        w_en = 1'b0;
        cycle();
        chk("ovf_clr", w_overflow, 0);
        ovf_clr = 1'b0;

        // Read pointer change from full
        rd = 4; r_gptr = gray(rd);
        chk("rg_drive", r_gptr, 5'b00110);
        cycle(); chk("rd_lat1", w_full, 1);
        cycle(); chk("rd_lat2", w_level, 16);
        cycle();
        chk("rd_lat3_full", w_full, 0);
        chk("rd_lat3_lvl", w_level, 12);
        chk("rd_lat3_af", w_almost_full, 1);

        // Random traffic through several pointer wraps
        start = wcnt; guard = 0;
        while ((wcnt - start < 40 || guard < 300) && guard < 3000) begin
            w_en = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            if (rd < wcnt && $urandom_range(0, 2) != 0) rd++;
            r_gptr = gray(rd);
            cycle();
            guard++;
        end
        chk("wrap_count", wcnt - start >= 40, 1);
        ovf_clr = 1'b0;

        // Drain, then write 7 and reset asynchronously mid-burst
        w_en = 1'b0; rd = wcnt; r_gptr = gray(rd);
        repeat (S + 1) cycle();
        w_en = 1'b1;
        repeat (7) cycle();
        chk("pre_rst_lvl", w_level, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gptr", w_gptr, 0);
        chk("arst_level", w_level, 0);
        chk("arst_addr", w_addr, 0);
        chk("arst_flags", {w_full, w_almost_full, w_overflow}, 0);
        model_reset();
        r_gptr = '0;
        @(negedge w_clk);
        rst_n = 1'b1;
        #1 chk("post_rst_addr", w_addr, 0);
        repeat (4) cycle();
        w_en = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
